// File: rtl/lvg_result_reader_if.sv
// Result stream from lvg_result_reader to the host/DMA readback path.
// The reader drives words, index, opcode and the valid/last flags; the consumer drives ready.
interface lvg_result_reader_if;
    logic [31:0] out_data;
    logic [3:0]  out_index;
    logic [7:0]  out_op;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output out_data,
        output out_index,
        output out_op,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_op,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/lvg_result_reader.sv
// lvg_result_reader: watches the lvg opcode bus, waits the fixed compute latency after
// each compute command, snapshots the 4x4 result matrix and streams it out row-major.
// A second countdown may run while a matrix drains; anything that cannot be kept is
// reported through the sticky overflow flag.
module lvg_result_reader #(
    parameter int unsigned LATENCY = 15,
    parameter logic [7:0]  OP_MIN  = 8'd5,
    parameter logic [7:0]  OP_MAX  = 8'd8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          instr_i,
    input  logic [31:0]         b11_i, b12_i, b13_i, b14_i,
    input  logic [31:0]         b21_i, b22_i, b23_i, b24_i,
    input  logic [31:0]         b31_i, b32_i, b33_i, b34_i,
    input  logic [31:0]         b41_i, b42_i, b43_i, b44_i,
    lvg_result_reader_if.master res,
    output logic                busy_o,
    output logic                overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] CNT_START = 8'(LATENCY - 32'd1);

    state_e      state_q;
    logic [7:0]  instr_q;
    logic [7:0]  cnt_q;
    logic        pend_q;
    logic [7:0]  op_pend_q;
    logic [31:0] res_q [16];
    logic [31:0] out_data_q;
    logic [3:0]  out_index_q;
    logic [7:0]  out_op_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        busy_q;
    logic        overflow_q;

    logic [31:0] b_s [16];
    logic        cmd_s;
    logic        hs_s;
    logic        drain_done_s;
    logic [3:0]  next_idx_s;

    assign b_s[0]  = b11_i;  assign b_s[1]  = b12_i;  assign b_s[2]  = b13_i;  assign b_s[3]  = b14_i;
    assign b_s[4]  = b21_i;  assign b_s[5]  = b22_i;  assign b_s[6]  = b23_i;  assign b_s[7]  = b24_i;
    assign b_s[8]  = b31_i;  assign b_s[9]  = b32_i;  assign b_s[10] = b33_i;  assign b_s[11] = b34_i;
    assign b_s[12] = b41_i;  assign b_s[13] = b42_i;  assign b_s[14] = b43_i;  assign b_s[15] = b44_i;

    // A compute opcode counts once: only on the cycle it first appears or changes.
    assign cmd_s        = (instr_i >= OP_MIN) && (instr_i <= OP_MAX) && (instr_i != instr_q);
    assign hs_s         = out_valid_q && res.out_ready;
    assign drain_done_s = hs_s && (out_index_q == 4'd15);
    assign next_idx_s   = out_index_q + 4'd1;

    assign res.out_data  = out_data_q;
    assign res.out_index = out_index_q;
    assign res.out_op    = out_op_q;
    assign res.out_valid = out_valid_q;
    assign res.out_last  = out_last_q;
    assign busy_o        = busy_q;
    assign overflow_o    = overflow_q;

    // Control FSM: command detection, latency countdown, matrix capture and drain sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            instr_q     <= 8'd0;
            cnt_q       <= 8'd0;
            pend_q      <= 1'b0;
            op_pend_q   <= 8'd0;
            out_data_q  <= 32'd0;
            out_index_q <= 4'd0;
            out_op_q    <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                res_q[i] <= 32'd0;
            end
        end else begin
            instr_q <= instr_i;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_s) begin
                        state_q   <= ST_WAIT;
                        cnt_q     <= CNT_START;
                        op_pend_q <= instr_i;
                        pend_q    <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cmd_s) begin
                        // Newer command supersedes the one in flight; its result is lost.
                        cnt_q      <= CNT_START;
                        op_pend_q  <= instr_i;
                        overflow_q <= 1'b1;
                    end else if (cnt_q == 8'd0) begin
                        for (int i = 0; i < 16; i++) begin
                            res_q[i] <= b_s[i];
                        end
                        out_data_q  <= b_s[0];
                        out_index_q <= 4'd0;
                        out_op_q    <= op_pend_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        pend_q      <= 1'b0;
                        state_q     <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_DRAIN: begin
                    // Background countdown for a command issued while draining.
                    if (cmd_s) begin
                        pend_q    <= 1'b1;
                        cnt_q     <= CNT_START;
                        op_pend_q <= instr_i;
                        if (pend_q) begin
                            overflow_q <= 1'b1;
                        end
                    end else if (pend_q) begin
                        if (cnt_q == 8'd0) begin
                            pend_q <= 1'b0;
                            if (!drain_done_s) begin
                                // Buffer still in use: this result has nowhere to go.
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end

                    if (drain_done_s) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (cmd_s) begin
                            state_q <= ST_WAIT;
                        end else if (pend_q && (cnt_q == 8'd0)) begin
                            // Countdown expires on the final handshake: capture straight away.
                            for (int i = 0; i < 16; i++) begin
                                res_q[i] <= b_s[i];
                            end
                            out_data_q  <= b_s[0];
                            out_index_q <= 4'd0;
                            out_op_q    <= op_pend_q;
                            out_valid_q <= 1'b1;
                        end else if (pend_q) begin
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (hs_s) begin
                        out_index_q <= next_idx_s;
                        out_data_q  <= res_q[next_idx_s];
                        out_last_q  <= (next_idx_s == 4'd15);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    pend_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
